// File: rtl/bsg_axil_store_unpacker_pkg.sv
// Shared AXI-Lite types and the packed command format used by the
// store packer/unpacker pair on either end of a command link.
package bsg_axil_store_unpacker_pkg;

  typedef enum logic [1:0] {
    e_axi_resp_okay   = 2'b00,
    e_axi_resp_exokay = 2'b01,
    e_axi_resp_slverr = 2'b10,
    e_axi_resp_decerr = 2'b11
  } axi_resp_type_e;

  typedef enum logic [2:0] {
    e_axi_prot_default    = 3'b000,
    e_axi_prot_privileged = 3'b001,
    e_axi_prot_nonsecure  = 3'b010,
    e_axi_prot_instr      = 3'b100
  } axi_prot_type_e;

  localparam int cmd_addr_width_lp = 23;
  localparam int cmd_data_width_lp = 8;

  typedef struct packed {
    logic                         wnr;
    logic [cmd_addr_width_lp-1:0] addr;
    logic [cmd_data_width_lp-1:0] data;
  } bsg_axil_store_cmd_s;

  localparam int cmd_width_lp = $bits(bsg_axil_store_cmd_s);

  // EXOKAY is not expected from an AXI-Lite slave, so it counts as an error too
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != e_axi_resp_okay;
  endfunction

endpackage

// File: rtl/bsg_axil_store_unpacker_if.sv
// Command/response stream interface and AXI-Lite master interface used
// by the store unpacker.
interface bsg_axil_store_unpacker_if;
  import bsg_axil_store_unpacker_pkg::*;

  logic [cmd_width_lp-1:0] data_i;
  logic                    v_i;
  logic                    ready_o;
  logic [31:0]             data_o;
  logic                    v_o;
  logic                    ready_i;

  modport slave  (input  data_i, v_i, ready_i, output ready_o, data_o, v_o);
  modport master (output data_i, v_i, ready_i, input  ready_o, data_o, v_o);
endinterface

interface bsg_axil_store_unpacker_axil_if
  #(parameter int axi_addr_width_p = 32
   ,parameter int axi_data_width_p = 32);

  logic [axi_addr_width_p-1:0]   m_axil_awaddr_o;
  logic [2:0]                    m_axil_awprot_o;
  logic                          m_axil_awvalid_o;
  logic                          m_axil_awready_i;
  logic [axi_data_width_p-1:0]   m_axil_wdata_o;
  logic [axi_data_width_p/8-1:0] m_axil_wstrb_o;
  logic                          m_axil_wvalid_o;
  logic                          m_axil_wready_i;
  logic [1:0]                    m_axil_bresp_i;
  logic                          m_axil_bvalid_i;
  logic                          m_axil_bready_o;
  logic [axi_addr_width_p-1:0]   m_axil_araddr_o;
  logic [2:0]                    m_axil_arprot_o;
  logic                          m_axil_arvalid_o;
  logic                          m_axil_arready_i;
  logic [axi_data_width_p-1:0]   m_axil_rdata_i;
  logic [1:0]                    m_axil_rresp_i;
  logic                          m_axil_rvalid_i;
  logic                          m_axil_rready_o;

  modport master (
    output m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o,
           m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o, m_axil_bready_o,
           m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o, m_axil_rready_o,
    input  m_axil_awready_i, m_axil_wready_i, m_axil_bresp_i, m_axil_bvalid_i,
           m_axil_arready_i, m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i
  );

  modport slave (
    input  m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o,
           m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o, m_axil_bready_o,
           m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o, m_axil_rready_o,
    output m_axil_awready_i, m_axil_wready_i, m_axil_bresp_i, m_axil_bvalid_i,
           m_axil_arready_i, m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i
  );
endinterface

// File: rtl/bsg_axil_store_unpacker.sv
// Turns packed {wnr, addr, data} commands into single AXI-Lite transactions,
// one in flight at a time; read data returns on the response stream.
module bsg_axil_store_unpacker
  import bsg_axil_store_unpacker_pkg::*;
  #(parameter int axi_addr_width_p = 32
   ,parameter int axi_data_width_p = 32
   ,parameter logic [axi_addr_width_p-1:0] base_addr_p = '0)
  (input  logic clk_i
  ,input  logic reset_i
  ,bsg_axil_store_unpacker_if.slave      link
  ,bsg_axil_store_unpacker_axil_if.master m_axil
  ,output logic err_o);

  localparam int strb_width_lp = axi_data_width_p/8;
  localparam logic [axi_addr_width_p-1:0] low_mask_lp =
    axi_addr_width_p'({cmd_addr_width_lp{1'b1}});

  typedef enum logic [2:0] {
    e_ready, e_write, e_write_resp, e_read_addr, e_read_resp, e_read_return
  } state_e;

  state_e                         state_reg;
  bsg_axil_store_cmd_s            cmd_li;
  logic [cmd_addr_width_lp-1:0]   addr_reg;
  logic [cmd_data_width_lp-1:0]   wdata_reg;
  logic [31:0]                    rdata_reg;
  logic                           aw_done_reg, w_done_reg, err_reg;
  logic                           awvalid_reg, wvalid_reg, bready_reg;
  logic                           arvalid_reg, rready_reg, v_o_reg, ready_reg;
  logic                           aw_done_next, w_done_next;
  logic [axi_addr_width_p-1:0]    addr_li;

  assign cmd_li       = link.data_i;
  assign aw_done_next = aw_done_reg | (awvalid_reg & m_axil.m_axil_awready_i);
  assign w_done_next  = w_done_reg  | (wvalid_reg  & m_axil.m_axil_wready_i);
  assign addr_li      = (base_addr_p & ~low_mask_lp) | axi_addr_width_p'(addr_reg);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg   <= e_ready;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      err_reg     <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      v_o_reg     <= 1'b0;
      ready_reg   <= 1'b1;
    end else begin
      case (state_reg)
        e_ready: if (link.v_i) begin
          addr_reg  <= cmd_li.addr;
          wdata_reg <= cmd_li.data;
          ready_reg <= 1'b0;
          if (cmd_li.wnr) begin
            state_reg   <= e_write;
            awvalid_reg <= 1'b1;
            wvalid_reg  <= 1'b1;
          end else begin
            state_reg   <= e_read_addr;
            arvalid_reg <= 1'b1;
          end
        end
        // AW and W finish independently; leave once both have, including this cycle
        e_write: if (aw_done_next & w_done_next) begin
          aw_done_reg <= 1'b0;
          w_done_reg  <= 1'b0;
          awvalid_reg <= 1'b0;
          wvalid_reg  <= 1'b0;
          bready_reg  <= 1'b1;
          state_reg   <= e_write_resp;
        end else begin
          aw_done_reg <= aw_done_next;
          w_done_reg  <= w_done_next;
          awvalid_reg <= ~aw_done_next;
          wvalid_reg  <= ~w_done_next;
        end
        e_write_resp: if (m_axil.m_axil_bvalid_i) begin
          err_reg    <= err_reg | resp_is_error(m_axil.m_axil_bresp_i);
          bready_reg <= 1'b0;
          ready_reg  <= 1'b1;
          state_reg  <= e_ready;
        end
        e_read_addr: if (m_axil.m_axil_arready_i) begin
          arvalid_reg <= 1'b0;
          rready_reg  <= 1'b1;
          state_reg   <= e_read_resp;
        end
        e_read_resp: if (m_axil.m_axil_rvalid_i) begin
          rdata_reg  <= m_axil.m_axil_rdata_i[31:0];
          err_reg    <= err_reg | resp_is_error(m_axil.m_axil_rresp_i);
          rready_reg <= 1'b0;
          v_o_reg    <= 1'b1;
          state_reg  <= e_read_return;
        end
        // rdata_reg is cleared on exit so data_o reads 0 whenever v_o is low
        e_read_return: if (link.ready_i) begin
          rdata_reg <= '0;
          v_o_reg   <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= e_ready;
        end
        default: begin
          state_reg <= e_ready;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign link.ready_o = ready_reg;
  assign link.v_o     = v_o_reg;
  assign link.data_o  = rdata_reg;
  assign err_o        = err_reg;

  assign m_axil.m_axil_awaddr_o  = addr_li;
  assign m_axil.m_axil_awprot_o  = e_axi_prot_default;
  assign m_axil.m_axil_awvalid_o = awvalid_reg;
  assign m_axil.m_axil_wdata_o   = axi_data_width_p'(wdata_reg);
  assign m_axil.m_axil_wstrb_o   = strb_width_lp'(1);
  assign m_axil.m_axil_wvalid_o  = wvalid_reg;
  assign m_axil.m_axil_bready_o  = bready_reg;
  assign m_axil.m_axil_araddr_o  = addr_li;
  assign m_axil.m_axil_arprot_o  = e_axi_prot_default;
  assign m_axil.m_axil_arvalid_o = arvalid_reg;
  assign m_axil.m_axil_rready_o  = rready_reg;

endmodule

// File: tb/tb_bsg_axil_store_unpacker.sv
// Randomized bench for the store unpacker; a behavioural AXI-Lite slave and
// an address/data/error model supply every expected value.
module tb_bsg_axil_store_unpacker;

  localparam logic [31:0] BASE = 32'h8180_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   err_model = 1'b0;

  always #5 clk = ~clk;

  bsg_axil_store_unpacker_if link_if();
  bsg_axil_store_unpacker_axil_if #(.axi_addr_width_p(32), .axi_data_width_p(32)) axil_if();

  bsg_axil_store_unpacker #(
    .axi_addr_width_p(32), .axi_data_width_p(32), .base_addr_p(BASE)
  ) dut (
    .clk_i(clk), .reset_i(rst), .link(link_if), .m_axil(axil_if), .err_o(err)
  );

  // Address the interconnect should see: base supplies the top bits, command the low 23
  function automatic logic [31:0] exp_addr(input logic [31:0] cmd);
    return (BASE & 32'hFF80_0000) | {9'b0, cmd[30:8]};
  endfunction

  task automatic send_cmd(input logic [31:0] cmd, output bit ok);
    ok = 1'b0;
    link_if.data_i = cmd;
    link_if.v_i    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (link_if.ready_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    link_if.v_i    = 1'b0;
    link_if.data_i = $urandom;
  endtask

  task automatic do_write(input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] bresp,
                          output int aw_beats, output int w_beats, output logic [31:0] awaddr,
                          output logic [31:0] wdata, output logic [3:0] wstrb,
                          output int viol, output bit timeout);
    int i = 0; int bcnt = 0; bit started = 0; bit bdone = 0; bit bv;
    aw_beats = 0; w_beats = 0; awaddr = '0; wdata = '0; wstrb = '0; viol = 0; timeout = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (!started && (axil_if.m_axil_awvalid_o || axil_if.m_axil_wvalid_o)) started = 1'b1;
      if (started) begin
        bv = (aw_beats > 0) && (w_beats > 0) && (bcnt >= b_dly);
        axil_if.m_axil_awready_i = (i >= aw_dly);
        axil_if.m_axil_wready_i  = (i >= w_dly);
        axil_if.m_axil_bvalid_i  = bv;
        axil_if.m_axil_bresp_i   = bv ? bresp : 2'($urandom);
        if (aw_beats > 0 && w_beats > 0) bcnt++;
        if (aw_beats == 0 && !axil_if.m_axil_awvalid_o) viol++;
        if (w_beats == 0 && !axil_if.m_axil_wvalid_o) viol++;
        if (link_if.ready_o || link_if.v_o || axil_if.m_axil_arvalid_o) viol++;
        if (axil_if.m_axil_awvalid_o && axil_if.m_axil_awready_i) begin
          if (aw_beats > 0 && awaddr !== axil_if.m_axil_awaddr_o) viol++;
          aw_beats++; awaddr = axil_if.m_axil_awaddr_o;
        end
        if (axil_if.m_axil_wvalid_o && axil_if.m_axil_wready_i) begin
          w_beats++; wdata = axil_if.m_axil_wdata_o; wstrb = axil_if.m_axil_wstrb_o;
        end
        bdone = bv && axil_if.m_axil_bready_o;
        i++;
      end
      @(negedge clk);
      if (bdone) begin timeout = 1'b0; break; end
    end
    axil_if.m_axil_awready_i = 1'b0;
    axil_if.m_axil_wready_i  = 1'b0;
    axil_if.m_axil_bvalid_i  = 1'b0;
  endtask

  task automatic do_read(input int ar_dly, input int r_dly, input int ret_dly,
                         input logic [31:0] rdata, input logic [1:0] rresp,
                         output int ar_beats, output logic [31:0] araddr, output logic [31:0] data,
                         output int v_cnt, output int viol, output bit timeout);
    int i = 0; int rcnt = 0; int r_beats = 0; bit started = 0; bit done = 0; bit rv;
    ar_beats = 0; araddr = '0; data = '0; v_cnt = 0; viol = 0; timeout = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (!started && axil_if.m_axil_arvalid_o) started = 1'b1;
      if (started) begin
        rv = (ar_beats > 0) && (r_beats == 0) && (rcnt >= r_dly);
        axil_if.m_axil_arready_i = (i >= ar_dly);
        axil_if.m_axil_rvalid_i  = rv;
        axil_if.m_axil_rdata_i   = rv ? rdata : $urandom;
        axil_if.m_axil_rresp_i   = rv ? rresp : 2'($urandom);
        link_if.ready_i          = (v_cnt >= ret_dly);
        if (ar_beats > 0) rcnt++;
        if (ar_beats == 0 && !axil_if.m_axil_arvalid_o) viol++;
        if (axil_if.m_axil_awvalid_o || axil_if.m_axil_wvalid_o || link_if.ready_o) viol++;
        if (!link_if.v_o && link_if.data_o !== 32'h0) viol++;
        if (link_if.v_o && v_cnt > 0 && link_if.data_o !== data) viol++;
        if (axil_if.m_axil_arvalid_o && axil_if.m_axil_arready_i) begin
          ar_beats++; araddr = axil_if.m_axil_araddr_o;
        end
        if (rv && axil_if.m_axil_rready_o) r_beats++;
        if (link_if.v_o) begin
          if (v_cnt == 0) data = link_if.data_o;
          v_cnt++;
          done = link_if.ready_i;
        end
        i++;
      end
      @(negedge clk);
      if (done) begin timeout = 1'b0; break; end
    end
    axil_if.m_axil_arready_i = 1'b0;
    axil_if.m_axil_rvalid_i  = 1'b0;
    link_if.ready_i          = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (link_if.ready_o !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b exp 1", link_if.ready_o); end
    tests_run++; if ({axil_if.m_axil_awvalid_o, axil_if.m_axil_wvalid_o, axil_if.m_axil_bready_o, axil_if.m_axil_arvalid_o, axil_if.m_axil_rready_o, link_if.v_o} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_valids got aw%b w%b b%b ar%b r%b v%b exp all 0", axil_if.m_axil_awvalid_o, axil_if.m_axil_wvalid_o, axil_if.m_axil_bready_o, axil_if.m_axil_arvalid_o, axil_if.m_axil_rready_o, link_if.v_o); end
    tests_run++; if (link_if.data_o !== 32'h0 || err !== 1'b0) begin tests_failed++; $display("FAIL reset_data_err got data %h err %b exp 0 0", link_if.data_o, err); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (link_if.ready_o !== 1'b1 || axil_if.m_axil_awvalid_o !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle got ready %b aw %b exp 1 0", link_if.ready_o, axil_if.m_axil_awvalid_o); end
  endtask

  task automatic run_write(input string name, input logic [31:0] cmd, input int aw_dly, input int w_dly,
                           input int b_dly, input logic [1:0] bresp);
    bit ok; bit to; int awb; int wb; int viol; logic [31:0] awaddr; logic [31:0] wdata; logic [3:0] wstrb;
    send_cmd(cmd, ok);
    do_write(aw_dly, w_dly, b_dly, bresp, awb, wb, awaddr, wdata, wstrb, viol, to);
    if (bresp != 2'b00) err_model = 1'b1;
    $display("[TB] %s write cmd=%08h awaddr=%08h wdata=%08h wstrb=%h bresp=%0d err=%b", name, cmd, awaddr, wdata, wstrb, bresp, err);
    tests_run++; if (!ok || to) begin tests_failed++; $display("FAIL %s_done got accept %b timeout %b exp 1 0", name, ok, to); end
    tests_run++; if (awb !== 1 || wb !== 1) begin tests_failed++; $display("FAIL %s_beats got aw %0d w %0d exp 1 1", name, awb, wb); end
    tests_run++; if (awaddr !== exp_addr(cmd)) begin tests_failed++; $display("FAIL %s_awaddr got %h exp %h", name, awaddr, exp_addr(cmd)); end
    tests_run++; if (wdata !== {24'h0, cmd[7:0]} || wstrb !== 4'h1) begin tests_failed++; $display("FAIL %s_wdata got %h/%h exp %h/1", name, wdata, wstrb, {24'h0, cmd[7:0]}); end
    tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL %s_protocol got %0d violations exp 0", name, viol); end
    tests_run++; if (err !== err_model || link_if.ready_o !== 1'b1 || link_if.v_o !== 1'b0) begin
      tests_failed++; $display("FAIL %s_after got err %b ready %b v %b exp %b 1 0", name, err, link_if.ready_o, link_if.v_o, err_model); end
  endtask

  task automatic run_read(input string name, input logic [31:0] cmd, input int ar_dly, input int r_dly,
                          input int ret_dly, input logic [31:0] rdata, input logic [1:0] rresp);
    bit ok; bit to; int arb; int vcnt; int viol; logic [31:0] araddr; logic [31:0] data;
    send_cmd(cmd, ok);
    do_read(ar_dly, r_dly, ret_dly, rdata, rresp, arb, araddr, data, vcnt, viol, to);
    if (rresp != 2'b00) err_model = 1'b1;
    $display("[TB] %s read cmd=%08h araddr=%08h data=%08h rresp=%0d v_cycles=%0d err=%b", name, cmd, araddr, data, rresp, vcnt, err);
    tests_run++; if (!ok || to) begin tests_failed++; $display("FAIL %s_done got accept %b timeout %b exp 1 0", name, ok, to); end
    tests_run++; if (arb !== 1 || araddr !== exp_addr(cmd)) begin tests_failed++; $display("FAIL %s_araddr got %0d beats addr %h exp 1 %h", name, arb, araddr, exp_addr(cmd)); end
    tests_run++; if (data !== rdata) begin tests_failed++; $display("FAIL %s_data got %h exp %h", name, data, rdata); end
    tests_run++; if (vcnt !== ret_dly + 1) begin tests_failed++; $display("FAIL %s_v_hold got %0d exp %0d", name, vcnt, ret_dly + 1); end
    tests_run++; if (viol !== 0) begin tests_failed++; $display("FAIL %s_protocol got %0d violations exp 0", name, viol); end
    tests_run++; if (err !== err_model || link_if.v_o !== 1'b0 || link_if.data_o !== 32'h0 || link_if.ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL %s_after got err %b v %b data %h ready %b exp %b 0 0 1", name, err, link_if.v_o, link_if.data_o, link_if.ready_o, err_model); end
  endtask

  task automatic test_write_same_cycle();
    run_write("wr_same", 32'h8000_1255, 0, 0, 0, 2'b00);
    tests_run++; if (axil_if.m_axil_awprot_o !== 3'b000 || axil_if.m_axil_arprot_o !== 3'b000) begin
      tests_failed++; $display("FAIL prot got %b %b exp 000 000", axil_if.m_axil_awprot_o, axil_if.m_axil_arprot_o); end
  endtask

  task automatic test_write_split();
    logic [31:0] r;
    r = $urandom; run_write("wr_aw_first", {1'b1, r[30:0]}, 0, 3, 1, 2'b00);
    r = $urandom; run_write("wr_w_first", {1'b1, r[30:0]}, 3, 0, 2, 2'b00);
  endtask

  task automatic test_read();
    run_read("rd_basic", 32'h0000_3400, 1, 2, 5, 32'hDEAD_BEEF, 2'b00);
  endtask

  task automatic test_error();
    logic [31:0] r;
    r = $urandom; run_write("err_slverr", {1'b1, r[30:0]}, 0, 0, 0, 2'b10);
    r = $urandom; run_write("err_sticky", {1'b1, r[30:0]}, 1, 0, 0, 2'b00);
    r = $urandom; run_read("err_decerr", {1'b0, r[30:0]}, 0, 1, 0, $urandom, 2'b11);
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, to1, to2; int awb, wb, arb, vcnt, viol1, viol2;
    logic [31:0] wcmd, rcmd, awaddr, wdata, araddr, data, rdat; logic [3:0] wstrb;
    wcmd = {1'b1, 31'($urandom)}; rcmd = {1'b0, 31'($urandom)}; rdat = $urandom;
    fork
      begin send_cmd(wcmd, ok1); send_cmd(rcmd, ok2); end
      begin
        do_write(2, 1, 1, 2'b00, awb, wb, awaddr, wdata, wstrb, viol1, to1);
        do_read(0, 0, 1, rdat, 2'b00, arb, araddr, data, vcnt, viol2, to2);
      end
    join
    $display("[TB] b2b write cmd=%08h awaddr=%08h then read cmd=%08h araddr=%08h data=%08h", wcmd, awaddr, rcmd, araddr, data);
    tests_run++; if (!ok1 || !ok2 || to1 || to2) begin tests_failed++; $display("FAIL b2b_done got acc %b%b timeout %b%b exp 11 00", ok1, ok2, to1, to2); end
    tests_run++; if (awb !== 1 || wb !== 1 || awaddr !== exp_addr(wcmd) || wdata !== {24'h0, wcmd[7:0]}) begin
      tests_failed++; $display("FAIL b2b_write got %0d/%0d %h %h exp 1/1 %h %h", awb, wb, awaddr, wdata, exp_addr(wcmd), {24'h0, wcmd[7:0]}); end
    tests_run++; if (arb !== 1 || araddr !== exp_addr(rcmd) || data !== rdat) begin
      tests_failed++; $display("FAIL b2b_read got %0d %h %h exp 1 %h %h", arb, araddr, data, exp_addr(rcmd), rdat); end
    tests_run++; if (viol1 !== 0 || viol2 !== 0) begin tests_failed++; $display("FAIL b2b_order got violations %0d %0d exp 0 0", viol1, viol2); end
  endtask

  task automatic test_async_reset();
    bit ok; logic [31:0] r;
    r = $urandom; send_cmd({1'b0, r[30:0]}, ok);
    tests_run++; if (!ok || axil_if.m_axil_arvalid_o !== 1'b1) begin tests_failed++; $display("FAIL ar_before_reset got acc %b arvalid %b exp 1 1", ok, axil_if.m_axil_arvalid_o); end
    axil_if.m_axil_arready_i = 1'b1;
    @(negedge clk);
    axil_if.m_axil_arready_i = 1'b0;
    tests_run++; if (axil_if.m_axil_rready_o !== 1'b1) begin tests_failed++; $display("FAIL rready_before_reset got %b exp 1", axil_if.m_axil_rready_o); end
    #2 rst = 1'b1;
    #1;
    err_model = 1'b0;
    $display("[TB] async reset asserted mid-read at %0t", $time);
    tests_run++; if ({axil_if.m_axil_arvalid_o, axil_if.m_axil_rready_o, link_if.v_o} !== 3'b000) begin
      tests_failed++; $display("FAIL async_drop got ar %b r %b v %b exp 0 0 0", axil_if.m_axil_arvalid_o, axil_if.m_axil_rready_o, link_if.v_o); end
    tests_run++; if (err !== 1'b0 || link_if.ready_o !== 1'b1) begin tests_failed++; $display("FAIL async_state got err %b ready %b exp 0 1", err, link_if.ready_o); end
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++; if (link_if.ready_o !== 1'b1 || axil_if.m_axil_rready_o !== 1'b0) begin tests_failed++; $display("FAIL post_async got ready %b rready %b exp 1 0", link_if.ready_o, axil_if.m_axil_rready_o); end
    r = $urandom; run_write("post_rst_wr", {1'b1, r[30:0]}, 1, 1, 0, 2'b00);
    r = $urandom; run_read("post_rst_rd", {1'b0, r[30:0]}, 1, 1, 1, $urandom, 2'b00);
  endtask

  task automatic test_random();
    logic [31:0] r; logic [1:0] resp;
    for (int n = 0; n < 30; n++) begin
      r = $urandom;
      resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (r[31]) run_write("rand", r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp);
      else       run_read("rand", r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, resp);
    end
  endtask

  initial begin
    link_if.data_i = '0; link_if.v_i = 1'b0; link_if.ready_i = 1'b0;
    axil_if.m_axil_awready_i = 1'b0; axil_if.m_axil_wready_i = 1'b0;
    axil_if.m_axil_bresp_i = 2'b00; axil_if.m_axil_bvalid_i = 1'b0;
    axil_if.m_axil_arready_i = 1'b0; axil_if.m_axil_rdata_i = '0;
    axil_if.m_axil_rresp_i = 2'b00; axil_if.m_axil_rvalid_i = 1'b0;
    #1 rst = 1'b1;
    test_reset();
    test_write_same_cycle();
    test_write_split();
    test_read();
    test_error();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
